// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Frame on the line: idle high, one start bit (0), DATA_BITS data bits LSB
// first, optional parity bit, then STOP_BITS stop bits (1). Every bit lasts
// CLKS_PER_BIT clk cycles.
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   Din    parallel word, captured when Valid && Ready
//   Valid  Din is offered for transmission
//   Ready  idle and able to accept a word (depends on state only)
//   Dout   registered serial line, idle high
//   Busy   frame in progress
//   Done   one-cycle pulse on the edge the frame completes
//
// States
//   state    | meaning
//   S_IDLE   | line high, waiting for Valid
//   S_START  | driving the start bit
//   S_DATA   | driving data bit bit_cnt
//   S_PARITY | driving the parity bit (only when PARITY != 0)
//   S_STOP   | driving stop bit bit_cnt

module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 7,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 Dout,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cyc_cnt, cyc_nxt;
  logic [BW-1:0]          bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic                   par_bit, par_nxt;
  logic                   dout_q, dout_nxt;
  logic                   done_q, done_nxt;
  logic                   bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      dout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      dout_q  <= dout_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bit_end = (cyc_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    dout_nxt  = dout_q;
    done_nxt  = 1'b0;
    // Cycle counter runs in every non-idle state and wraps at each bit end.
    if (state == S_IDLE || bit_end) cyc_nxt = '0;
    else                            cyc_nxt = cyc_cnt + 1'b1;

    case (state)
      S_IDLE: begin
        dout_nxt = 1'b1;
        if (Valid) begin
          state_nxt = S_START;
          shreg_nxt = Din;
          // Parity is fixed at capture so later Din changes cannot leak in.
          par_nxt   = (PARITY == 2) ? ~(^Din) : ^Din;
          bit_nxt   = '0;
          dout_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          dout_nxt  = shreg[0];
          shreg_nxt = shreg >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              dout_nxt  = par_bit;
            end else begin
              state_nxt = S_STOP;
              dout_nxt  = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            dout_nxt  = shreg[0];
            shreg_nxt = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
          dout_nxt  = 1'b1;
        end
      end
      S_STOP: begin
        dout_nxt = 1'b1;
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt = S_IDLE;
            bit_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dout_nxt  = 1'b1;
      end
    endcase
  end

  assign Ready = (state == S_IDLE);
  assign Busy  = (state != S_IDLE);
  assign Dout  = dout_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// Four instances cover the parameter sets:
//   unit 0: defaults (no parity, 1 stop)
//   unit 1: even parity
//   unit 2: odd parity
//   unit 3: 2 stop bits, feeding a behavioural receiver for loopback
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] din;
  logic [3:0] valid;
  logic [3:0] ready_w, dout_w, busy_w, done_w;

  int errors = 0;
  int checks = 0;

  logic [6:0] rx_q[$];
  logic [6:0] rx_w;
  logic       rx_prev;

  always #5 clk = ~clk;

  uart_tx u0 (.clk(clk), .rst(rst), .Din(din), .Valid(valid[0]),
              .Ready(ready_w[0]), .Dout(dout_w[0]), .Busy(busy_w[0]), .Done(done_w[0]));
  uart_tx #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .Din(din), .Valid(valid[1]),
              .Ready(ready_w[1]), .Dout(dout_w[1]), .Busy(busy_w[1]), .Done(done_w[1]));
  uart_tx #(.PARITY(2)) u2 (.clk(clk), .rst(rst), .Din(din), .Valid(valid[2]),
              .Ready(ready_w[2]), .Dout(dout_w[2]), .Busy(busy_w[2]), .Done(done_w[2]));
  uart_tx #(.STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .Din(din), .Valid(valid[3]),
              .Ready(ready_w[3]), .Dout(dout_w[3]), .Busy(busy_w[3]), .Done(done_w[3]));

  typedef struct {
    int         unit;
    logic [6:0] w;
    logic       par;   // expected parity bit (parity units only)
    int         len;   // cycles from acceptance to Done
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int unit, input logic [6:0] w,
                                   input logic par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 7) return w[k-1];
    if (k == 8 && (unit == 1 || unit == 2)) return par;
    return 1'b1;
  endfunction

  // Called at #1 after the acceptance edge; checks every cycle up to and
  // including the Done cycle.
  task automatic frame_check(input int unit, input logic [6:0] w,
                             input logic par, input int len);
    for (int c = 0; c <= len; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c < len) begin
        check($sformatf("u%0d w%h c%0d dout", unit, w, c), dout_w[unit],
              exp_bit(unit, w, par, c / 16));
        check($sformatf("u%0d w%h c%0d ready", unit, w, c), ready_w[unit], 1'b0);
        check($sformatf("u%0d w%h c%0d busy", unit, w, c), busy_w[unit], 1'b1);
        check($sformatf("u%0d w%h c%0d done", unit, w, c), done_w[unit], 1'b0);
      end else begin
        check($sformatf("u%0d w%h end dout", unit, w), dout_w[unit], 1'b1);
        check($sformatf("u%0d w%h end done", unit, w), done_w[unit], 1'b1);
        check($sformatf("u%0d w%h end ready", unit, w), ready_w[unit], 1'b1);
        check($sformatf("u%0d w%h end busy", unit, w), busy_w[unit], 1'b0);
      end
    end
  endtask

  task automatic send(input vec_t v);
    din = v.w;
    valid[v.unit] = 1'b1;
    @(posedge clk);
    #1;
    valid[v.unit] = 1'b0;
    frame_check(v.unit, v.w, v.par, v.len);
    @(posedge clk);
    #1;
    check($sformatf("u%0d w%h done width", v.unit, v.w), done_w[v.unit], 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Behavioural receiver on unit 3: mid-bit sampling after the falling edge.
  initial begin : rx_model
    rx_prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rx_prev === 1'b1 && dout_w[3] === 1'b0) begin
        repeat (8) @(posedge clk);
        for (int i = 0; i < 7; i++) begin
          repeat (16) @(posedge clk);
          #1;
          rx_w[i] = dout_w[3];
        end
        repeat (16) @(posedge clk);
        #1;
        if (dout_w[3] === 1'b1) rx_q.push_back(rx_w);
      end
      rx_prev = dout_w[3];
    end
  end

  initial begin
    int done_cnt;
    int low_cnt;

    vecs[0] = '{0, 7'h55, 1'b0, 144};
    vecs[1] = '{0, 7'h00, 1'b0, 144};
    vecs[2] = '{1, 7'h13, 1'b1, 160};
    vecs[3] = '{2, 7'h13, 1'b0, 160};
    vecs[4] = '{1, 7'h7F, 1'b1, 160};
    vecs[5] = '{2, 7'h00, 1'b1, 160};
    vecs[6] = '{3, 7'h00, 1'b0, 160};
    vecs[7] = '{3, 7'h7F, 1'b0, 160};
    vecs[8] = '{3, 7'h5A, 1'b0, 160};

    // Reset with Valid asserted: no start bit may appear.
    rst = 1'b1;
    valid = 4'hF;
    din = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++)
      check($sformatf("u%0d in-reset dout", u), dout_w[u], 1'b1);
    rst = 1'b0;
    valid = 4'h0;
    @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("u%0d rst dout", u), dout_w[u], 1'b1);
      check($sformatf("u%0d rst ready", u), ready_w[u], 1'b1);
      check($sformatf("u%0d rst busy", u), busy_w[u], 1'b0);
      check($sformatf("u%0d rst done", u), done_w[u], 1'b0);
    end

    for (int i = 0; i < 9; i++) send(vecs[i]);

    // Back-to-back with Din changing mid-frame.
    din = 7'h41;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        repeat (50) @(posedge clk);
        #1;
        din = 7'h7F;
      end
    join_none
    frame_check(0, 7'h41, 1'b0, 144);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    frame_check(0, 7'h7F, 1'b0, 144);
    repeat (3) @(posedge clk);
    #1;

    // Reset during data bit 3.
    din = 7'h55;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("midrst pre dout", dout_w[0], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst dout", dout_w[0], 1'b1);
    check("midrst ready", ready_w[0], 1'b1);
    check("midrst busy", busy_w[0], 1'b0);
    check("midrst done", done_w[0], 1'b0);
    done_cnt = 0;
    low_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (done_w[0] !== 1'b0) done_cnt++;
      if (dout_w[0] !== 1'b1) low_cnt++;
    end
    check_int("midrst late done", done_cnt, 0);
    check_int("midrst line low", low_cnt, 0);
    send('{0, 7'h2A, 1'b0, 144});

    // Loopback results from unit 3.
    repeat (20) @(posedge clk);
    #1;
    check_int("rx count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check_int("rx word0", int'(rx_q[0]), 'h00);
      check_int("rx word1", int'(rx_q[1]), 'h7F);
      check_int("rx word2", int'(rx_q[2]), 'h5A);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
